// File: rtl/moore_serial_bit_transmitter.sv
// Moore serial framer: start bit (0), WIDTH data bits MSB first, GAP stop bits (1).
// Outputs decode only registered state; zero_count reports the last completed frame.
module moore_serial_bit_transmitter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x_out,
  output logic             busy,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] zero_count
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [CNT_W-1:0]   tally_q;
  logic [CNT_W-1:0]   zero_q;
  logic               msb_zero;
  logic               accept;
  logic [CNT_W-1:0]   tally_d;

  assign data_ready = (state_q == IDLE) || ((state_q == STOP) && (gap_q == '0));
  assign accept     = data_valid && data_ready;
  assign msb_zero   = ~shift_q[WIDTH-1];
  assign tally_d    = tally_q + CNT_W'(msb_zero);

  assign x_out      = (state_q == START) ? 1'b0 :
                      (state_q == DATA)  ? shift_q[WIDTH-1] : 1'b1;
  assign busy       = (state_q != IDLE);
  assign state_out  = state_q;
  assign zero_count = zero_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      tally_q   <= '0;
      zero_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_in;
            state_q <= START;
          end
        end
        START: begin
          bit_cnt_q <= BIT_W'(WIDTH - 1);
          state_q   <= DATA;
        end
        DATA: begin
          shift_q <= shift_q << 1;
          if (bit_cnt_q == '0) begin
            // Final tally includes the bit on the line during this last DATA cycle.
            zero_q  <= tally_d;
            tally_q <= '0;
            gap_q   <= GAP_W'(GAP - 1);
            state_q <= STOP;
          end else begin
            tally_q   <= tally_d;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (gap_q == '0) begin
            if (accept) begin
              shift_q <= data_in;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/moore_serial_bit_transmitter.md
Name: moore_serial_bit_transmitter

Overview:
Moore-style serial transmitter that produces the single-bit line stream consumed by the team's zero-detector FSMs. Accepts a parallel word over a valid/ready handshake and frames it on x_out as: one start bit (0), WIDTH data bits MSB first, then GAP stop bits (1). Line idles at 1. Every output is a function of the registered state/datapath only (Moore). Per-frame zero-count and state code are exported for checking against the detector downstream.

Parameters:
WIDTH, 8, data word width; legal range 1..16
GAP, 1, stop/idle-high cycles after data; legal range 1..15
CNT_W, 4, zero_count width; must satisfy 2^CNT_W-1 >= WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  word to transmit; sampled on accept
data_valid  input  1  producer has a word
data_ready  output  1  transmitter can accept a word this cycle
x_out  output  1  serial line output
busy  output  1  high in START, DATA and STOP
state_out  output  2  current state code
zero_count  output  CNT_W  number of 0 data bits in last completed frame

Behaviour:
- Reset (reset=0, async, immediate): state=IDLE, shift reg=0, bit counter=0, gap counter=0, zero_count=0; x_out=1, data_ready=1, busy=0, state_out=2'b00. Holds while reset=0.
- States/encoding: IDLE=00, START=01, DATA=10, STOP=11.
- Accept = data_valid && data_ready at a rising edge; data_in latched into shift reg on that edge.
- IDLE: x_out=1, data_ready=1. On accept -> START; else stay.
- START: x_out=0, data_ready=0; unconditionally -> DATA next edge, bit counter=WIDTH-1.
- DATA: x_out=shift_reg[WIDTH-1]; each edge shifts left by 1 (0 fill), bit counter decrements, running zero tally increments when emitted bit is 0. When bit counter==0 at edge -> STOP, gap counter=GAP-1, zero_count<=final tally (includes last bit), running tally cleared.
- STOP: x_out=1. data_ready=1 only when gap counter==0 (final stop cycle), else 0. At edge with gap counter==0: accept -> START (back-to-back, no IDLE cycle); else -> IDLE. Otherwise gap counter decrements, stay.
- Frame length: 1+WIDTH+GAP cycles; back-to-back period identical (no dead cycles).
- Latency: x_out goes 0 in the cycle immediately after the accept edge.
- data_valid with data_ready=0: ignored, no latching; producer must hold (standard valid/ready). data_in changes during a frame have no effect.
- zero_count: updates only on DATA->STOP edge; stable otherwise, including across IDLE. Start bit not counted.
- busy = (state != IDLE). state_out = state register.
- Reset mid-frame: frame aborted, x_out returns to 1 immediately (asynchronous), zero_count cleared, partial tally discarded; after release, IDLE with data_ready=1.
- No X propagation: all registers reset; illegal state encodings do not exist (2 bits, 4 states used).

Test Plan:
- Idle: reset release, data_valid=0 for 10 cycles -> x_out=1, data_ready=1, busy=0, state_out=00 throughout, zero_count=0.
- Single frame 0xA5 (WIDTH=8, GAP=1): accept at edge T0 -> x_out per cycle after T0 = 0,1,0,1,0,0,1,0,1,1 then 1 (IDLE); zero_count=4 after DATA->STOP edge; state_out sequence 01,10x8,11,00.
- Extremes: 0x00 -> zero_count=8, x_out low for 9 consecutive cycles; 0xFF -> zero_count=0, x_out low only for start cycle.
- Back-to-back 0x3C then 0x81 with data_valid held high: second accept in final STOP cycle, START follows immediately; period exactly 10 cycles; zero_count=4 then 6; data_ready low in START/DATA.
- Reset mid-frame: assert reset=0 during 4th data bit of 0x0F, 2 ns pulse -> x_out=1 and state_out=00 immediately, zero_count=0; next accepted 0xF0 transmits correctly, zero_count=4.
- GAP=3 build: frame 0x55 -> three stop cycles of 1, data_ready high only in third; zero_count=4.
